// File: rtl/maxpool_ch_sequencer.sv
// Time-multiplexed 2x2 binary max-pool: one shared core, one channel per clock, IC+1 edges start->done.
// start is sampled only when idle; requests while busy are dropped (no queuing).

module maxpool_core #(
  parameter int IMG_IN_SIZE  = 28,
  parameter int IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
  input  logic [IMG_IN_SIZE**2-1:0]  img,
  output logic [IMG_OUT_SIZE**2-1:0] pooled
);
  // Binary max over a 2x2 window reduces to an OR of the four pixels.
  for (genvar i = 0; i < IMG_OUT_SIZE; i++) begin : g_row
    for (genvar j = 0; j < IMG_OUT_SIZE; j++) begin : g_col
      assign pooled[i*IMG_OUT_SIZE+j] =
          img[(2*i)*IMG_IN_SIZE+2*j]   | img[(2*i)*IMG_IN_SIZE+2*j+1] |
          img[(2*i+1)*IMG_IN_SIZE+2*j] | img[(2*i+1)*IMG_IN_SIZE+2*j+1];
    end
  end
endmodule

module maxpool_ch_sequencer #(
  parameter int IMG_IN_SIZE  = 28,
  parameter int IMG_OUT_SIZE = IMG_IN_SIZE / 2,
  parameter int IC           = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [IC-1:0][IMG_IN_SIZE**2-1:0]      img_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(IC+1)-1:0]                cur_ch,
  output logic [IC-1:0][IMG_OUT_SIZE**2-1:0]     img_out
);
  localparam int IN_BITS  = IMG_IN_SIZE**2;
  localparam int OUT_BITS = IMG_OUT_SIZE**2;
  localparam int CW       = $clog2(IC+1);
  localparam logic [CW-1:0] LAST_CH = CW'(IC-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cur_ch_q, cur_ch_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         wr_en_q, wr_en_d;
  logic [CW-1:0]                wr_ch_q, wr_ch_d;
  logic [IN_BITS-1:0]           in_reg_q, in_reg_d;
  logic [IC-1:0][OUT_BITS-1:0]  img_out_q, img_out_d;
  logic [OUT_BITS-1:0]          pool_out;

  maxpool_core #(
    .IMG_IN_SIZE  (IMG_IN_SIZE),
    .IMG_OUT_SIZE (IMG_OUT_SIZE)
  ) u_core (
    .img    (in_reg_q),
    .pooled (pool_out)
  );

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    wr_ch_d  = wr_ch_q;
    in_reg_d = in_reg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cur_ch_d = '0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        in_reg_d = img_in[cur_ch_q];
        wr_ch_d  = cur_ch_q;
        wr_en_d  = 1'b1;
        if (cur_ch_q == LAST_CH) begin
          state_d = DRAIN;
        end else begin
          cur_ch_d = cur_ch_q + CW'(1);
        end
      end
      DRAIN: begin
        // Final write lands on this same edge via wr_en_q.
        state_d  = IDLE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        cur_ch_d = '0;
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        cur_ch_d = '0;
      end
    endcase
  end

  always_comb begin
    img_out_d = img_out_q;
    if (wr_en_q) begin
      img_out_d[wr_ch_q] = pool_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_ch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_ch_q   <= '0;
      in_reg_q  <= '0;
      img_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_ch_q   <= wr_ch_d;
      in_reg_q  <= in_reg_d;
      img_out_q <= img_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_ch  = cur_ch_q;
  assign img_out = img_out_q;

endmodule
